// File: rtl/bp_fe_fetch_buffer.sv
// ---------------------------------------------------------------------------
// bp_fe_fetch_buffer
//
// Purpose:
//   Elastic FIFO that sits directly downstream of PC generation / I$ fetch.
//   Each fetched instruction is captured together with its PC, its branch
//   metadata and its fetch-exception flag. Entries are presented in order to
//   the FE queue enqueue logic. A BE redirect (flush_i) drops every entry
//   that is in flight.
//
// Ports:
//   clk_i           clock
//   reset_n_i       asynchronous active-low reset
//   flush_i         BE redirect: discard all entries; highest priority
//   enq_v_i         fetch result valid (valid-then-ready handshake)
//   enq_ready_o     buffer can accept this cycle (~full & ~flush_i)
//   enq_pc_i        fetch PC
//   enq_instr_i     fetched instruction
//   enq_bmeta_i     branch metadata forward payload (opaque)
//   enq_exc_i       fetch exception flag
//   deq_v_o         head entry valid
//   deq_yumi_i      consumer takes the head; only legal while deq_v_o is high
//   deq_pc_o        head PC
//   deq_instr_o     head instruction
//   deq_bmeta_o     head branch metadata
//   deq_exc_o       head exception flag
//   count_o         registered occupancy, 0..els_p
//   overflow_err_o  sticky debug flag: enq_v_i was dropped while full
//
// Configuration:
//   BP_FE_FETCH_BUF_BYPASS_EN  when defined, an enqueue into an empty buffer
//                              is visible on deq_* in the same cycle. If that
//                              entry is also taken the same cycle, it is
//                              never written. When undefined, the minimum
//                              latency is one cycle and there is no
//                              combinational path from enq_* to deq_*.
// ---------------------------------------------------------------------------
module bp_fe_fetch_buffer #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int bmeta_width_p = 64,
  parameter int els_p         = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       enq_v_i,
  output logic                       enq_ready_o,
  input  logic [vaddr_width_p-1:0]   enq_pc_i,
  input  logic [instr_width_p-1:0]   enq_instr_i,
  input  logic [bmeta_width_p-1:0]   enq_bmeta_i,
  input  logic                       enq_exc_i,
  output logic                       deq_v_o,
  input  logic                       deq_yumi_i,
  output logic [vaddr_width_p-1:0]   deq_pc_o,
  output logic [instr_width_p-1:0]   deq_instr_o,
  output logic [bmeta_width_p-1:0]   deq_bmeta_o,
  output logic                       deq_exc_o,
  output logic [$clog2(els_p+1)-1:0] count_o,
  output logic                       overflow_err_o
);

  localparam int idx_w = $clog2(els_p);
  localparam int ptr_w = idx_w + 1;        // extra MSB is the wrap bit
  localparam int cnt_w = $clog2(els_p + 1);

  // Pointers and occupancy
  logic [ptr_w-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ptr_w-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ptr_w-1:0] ptr_diff;
  logic [cnt_w-1:0] count_reg;
  logic             overflow_reg;

  logic [idx_w-1:0] rd_idx, wr_idx;
  logic             empty, full;
  logic             enq_fire, deq_fire;
  logic             bypass_hit;
  logic             write_en, rd_adv;

  // Storage (not reset; contents are don't-care while not valid)
  logic [vaddr_width_p-1:0] mem_pc    [els_p];
  logic [instr_width_p-1:0] mem_instr [els_p];
  logic [bmeta_width_p-1:0] mem_bmeta [els_p];
  logic                     mem_exc   [els_p];

  assign rd_idx = rd_ptr_reg[idx_w-1:0];
  assign wr_idx = wr_ptr_reg[idx_w-1:0];

  assign empty = (rd_ptr_reg == wr_ptr_reg);
  assign full  = (rd_idx == wr_idx) && (rd_ptr_reg[idx_w] != wr_ptr_reg[idx_w]);

  // Ready deliberately ignores deq_yumi_i: a full buffer never accepts,
  // even when the head leaves in the same cycle.
  assign enq_ready_o = ~full & ~flush_i;
  assign enq_fire    = enq_v_i & enq_ready_o;

`ifdef BP_FE_FETCH_BUF_BYPASS_EN
  // Empty buffer: the incoming entry is presented straight to the consumer.
  assign bypass_hit = empty & enq_fire;
  assign deq_v_o    = (~empty | enq_fire) & ~flush_i;
  assign deq_pc_o    = bypass_hit ? enq_pc_i    : mem_pc[rd_idx];
  assign deq_instr_o = bypass_hit ? enq_instr_i : mem_instr[rd_idx];
  assign deq_bmeta_o = bypass_hit ? enq_bmeta_i : mem_bmeta[rd_idx];
  assign deq_exc_o   = bypass_hit ? enq_exc_i   : mem_exc[rd_idx];
`else
  assign bypass_hit  = 1'b0;
  assign deq_v_o     = ~empty & ~flush_i;
  assign deq_pc_o    = mem_pc[rd_idx];
  assign deq_instr_o = mem_instr[rd_idx];
  assign deq_bmeta_o = mem_bmeta[rd_idx];
  assign deq_exc_o   = mem_exc[rd_idx];
`endif

  assign deq_fire = deq_yumi_i & deq_v_o;

  // A bypassed entry that is consumed immediately never touches storage or
  // the pointers; a bypassed entry that is not consumed is written normally.
  assign write_en = enq_fire & ~(bypass_hit & deq_fire);
  assign rd_adv   = deq_fire & ~bypass_hit;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (write_en) begin
      wr_ptr_next = wr_ptr_reg + ptr_w'(1);
    end
    // Flush empties the buffer; enqueue is already blocked by enq_ready_o.
    if (flush_i) begin
      rd_ptr_next = wr_ptr_reg;
    end else if (rd_adv) begin
      rd_ptr_next = rd_ptr_reg + ptr_w'(1);
    end
  end

  // Modular difference of the next pointers gives the next occupancy.
  assign ptr_diff = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= cnt_w'(ptr_diff);
      if (enq_v_i & full & ~flush_i) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem_pc[wr_idx]    <= enq_pc_i;
      mem_instr[wr_idx] <= enq_instr_i;
      mem_bmeta[wr_idx] <= enq_bmeta_i;
      mem_exc[wr_idx]   <= enq_exc_i;
    end
  end

  assign count_o        = count_reg;
  assign overflow_err_o = overflow_reg;

  // Taking the head while nothing is presented is a protocol violation.
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                     deq_yumi_i |-> deq_v_o);

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_fetch_buffer
//
// Scoreboard bench for bp_fe_fetch_buffer (els_p = 4). Accepted entries are
// pushed to a queue when driven; dequeued entries are popped and compared.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising edge.
// ---------------------------------------------------------------------------
module tb_bp_fe_fetch_buffer;

  localparam int VA = 39;
  localparam int IW = 32;
  localparam int BW = 64;
  localparam int ELS = 4;
  localparam int CW = $clog2(ELS + 1);
`ifdef BP_FE_FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          flush_i;
  logic          enq_v_i;
  logic          enq_ready_o;
  logic [VA-1:0] enq_pc_i;
  logic [IW-1:0] enq_instr_i;
  logic [BW-1:0] enq_bmeta_i;
  logic          enq_exc_i;
  logic          deq_v_o;
  logic          deq_yumi_i;
  logic [VA-1:0] deq_pc_o;
  logic [IW-1:0] deq_instr_o;
  logic [BW-1:0] deq_bmeta_o;
  logic          deq_exc_o;
  logic [CW-1:0] count_o;
  logic          overflow_err_o;

  always #5 clk_i = ~clk_i;

  bp_fe_fetch_buffer #(
    .vaddr_width_p(VA),
    .instr_width_p(IW),
    .bmeta_width_p(BW),
    .els_p        (ELS)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .flush_i       (flush_i),
    .enq_v_i       (enq_v_i),
    .enq_ready_o   (enq_ready_o),
    .enq_pc_i      (enq_pc_i),
    .enq_instr_i   (enq_instr_i),
    .enq_bmeta_i   (enq_bmeta_i),
    .enq_exc_i     (enq_exc_i),
    .deq_v_o       (deq_v_o),
    .deq_yumi_i    (deq_yumi_i),
    .deq_pc_o      (deq_pc_o),
    .deq_instr_o   (deq_instr_o),
    .deq_bmeta_o   (deq_bmeta_o),
    .deq_exc_o     (deq_exc_o),
    .count_o       (count_o),
    .overflow_err_o(overflow_err_o)
  );

  typedef struct {
    logic [VA-1:0] pc;
    logic [IW-1:0] instr;
    logic [BW-1:0] bmeta;
    logic          exc;
  } ent_t;

  ent_t sb[$];
  int   chk_count  = 0;
  int   fail_count = 0;
  logic m_ovf      = 1'b0;
  logic [VA-1:0] next_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, checks and model update.
  // 'yumi' is a request; it is only driven when the model says the head is valid.
  task automatic cyc(input logic ev, input logic [VA-1:0] pc, input logic [IW-1:0] instr,
                     input logic exc, input logic yumi, input logic fl, output logic accepted);
    logic m_ready, m_acc, m_dv, take;
    ent_t inc, head;
    @(negedge clk_i);
    inc.pc    = pc;
    inc.instr = instr;
    inc.bmeta = {$urandom, $urandom};
    inc.exc   = exc;
    m_ready = (sb.size() < ELS) && !fl;
    m_acc   = ev && m_ready;
    m_dv    = ((sb.size() > 0) || (BYP && m_acc)) && !fl;
    take    = yumi && m_dv;
    enq_v_i     = ev;
    enq_pc_i    = inc.pc;
    enq_instr_i = inc.instr;
    enq_bmeta_i = inc.bmeta;
    enq_exc_i   = inc.exc;
    deq_yumi_i  = take;
    flush_i     = fl;
    #1;
    check("enq_ready", 64'(enq_ready_o), 64'(m_ready));
    check("deq_v", 64'(deq_v_o), 64'(m_dv));
    check("count", 64'(count_o), 64'(sb.size()));
    check("overflow_err", 64'(overflow_err_o), 64'(m_ovf));
    if (m_dv) begin
      head = (sb.size() > 0) ? sb[0] : inc;
      check("deq_pc", 64'(deq_pc_o), 64'(head.pc));
      check("deq_exc", 64'(deq_exc_o), 64'(head.exc));
      if (take) begin
        check("deq_instr", 64'(deq_instr_o), 64'(head.instr));
        check("deq_bmeta", deq_bmeta_o, head.bmeta);
        $display("deq pc=0x%0h instr=0x%0h exc=%0d count=%0d", deq_pc_o, deq_instr_o,
                 deq_exc_o, count_o);
      end
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (ev && sb.size() == ELS) m_ovf = 1'b1;
      if (m_acc) sb.push_back(inc);
      if (take) void'(sb.pop_front());
    end
    accepted = m_acc;
  endtask

  task automatic idle();
    logic a;
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, a);
  endtask

  initial begin
    logic acc;
    reset_n_i = 1'b0;
    flush_i = 1'b0; enq_v_i = 1'b0; deq_yumi_i = 1'b0;
    enq_pc_i = '0; enq_instr_i = '0; enq_bmeta_i = '0; enq_exc_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_deq_v", 64'(deq_v_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_overflow", 64'(overflow_err_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // 1: single entry, one-cycle latency (bypass: same cycle)
    cyc(1'b1, 39'h0_8000_0000, 32'h0000_0013, 1'b0, BYP, 1'b0, acc);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    idle();

    // 2: fill to four, then hold a fifth valid while full -> overflow
    for (int i = 0; i < 4; i++) cyc(1'b1, 39'(32'h100 + 4 * i), 32'(i), 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b1, 39'h110, 32'h4, 1'b0, 1'b0, 1'b0, acc);
    idle();

    // 3: full with enqueue and yumi every cycle; PCs continue +4
    next_pc = 39'h110;
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, next_pc, 32'(i + 16), 1'b0, 1'b1, 1'b0, acc);
      if (acc) next_pc = next_pc + 39'd4;
    end

    // 4: drain, put three in, then flush with enq_v_i and no yumi
    for (int i = 0; i < 8 && sb.size() > 0; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) cyc(1'b1, 39'(32'h300 + 4 * i), 32'(i), 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b1, 39'h30C, 32'h9, 1'b0, 1'b0, 1'b1, acc);
    idle();

    // 5: exception entry sandwiched between two normal fetches
    cyc(1'b1, 39'h1FFC, 32'hA, 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b1, 39'h2000, 32'hB, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 39'h2004, 32'hC, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    idle();

    // 6: asynchronous reset in the middle of a cycle with two entries held
    cyc(1'b1, 39'h500, 32'h1, 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b1, 39'h504, 32'h2, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk_i);
    enq_v_i = 1'b0; deq_yumi_i = 1'b0; flush_i = 1'b0;
    #1;
    check("pre_arst_count", 64'(count_o), 64'd2);
    #1 reset_n_i = 1'b0;
    #1;
    check("arst_deq_v", 64'(deq_v_o), 64'd0);
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_overflow", 64'(overflow_err_o), 64'd0);
    sb.delete();
    m_ovf = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    idle();

    // Mixed random traffic with occasional flushes
    next_pc = 39'h4000;
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom % 4) != 0, next_pc, $urandom, ($urandom % 8) == 0,
          ($urandom % 2) == 0, ($urandom % 16) == 0, acc);
      if (acc) next_pc = next_pc + 39'd4;
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
    $finish;
  end

endmodule
